// File: rtl/dct_pkg.sv
// Shared DCT pipeline constants and the row-issue state encoding.
// Used by the row scheduler, the 2-D DCT and the parallel-to-serial stage.
package dct_pkg;

    localparam int PIX_W    = 12;
    localparam int ROW_N    = 8;
    localparam int ROW_W    = PIX_W * ROW_N;
    localparam int BLK_ROWS = 8;
    localparam int SLOT_CYC = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/row_fifo.sv
// Small first-word-fall-through row buffer; head is valid whenever empty is low.
// Pushes while full and pops while empty are dropped internally.
module row_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dct_row_scheduler.sv
// Feeds buffered pixel rows into the 2-D DCT one per slot, raises start at a fixed
// slot phase, limits blocks in flight and counts data_en returns into blk_done.
module dct_row_scheduler
    import dct_pkg::*;
#(
    parameter int START_PHASE  = 7,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             row_valid,
    input  logic [ROW_W-1:0] row_data,
    output logic             row_ready,
    output logic [ROW_W-1:0] DCT_data_in,
    output logic             start,
    input  logic             data_en,
    output logic             blk_first,
    output logic             blk_last,
    output logic             blk_done,
    output logic [1:0]       inflight,
    output logic             busy
);

    localparam int SLOT_W    = $clog2(SLOT_CYC);
    localparam int ROW_IDX_W = $clog2(BLK_ROWS);

    localparam logic [SLOT_W-1:0]    SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0]    START_SLOT = SLOT_W'(START_PHASE);
    localparam logic [ROW_IDX_W-1:0] ROW_LAST   = ROW_IDX_W'(BLK_ROWS - 1);
    localparam logic [1:0]           INFL_MAX   = 2'(MAX_INFLIGHT);

    sched_state_t         state_reg,    state_next;
    logic [SLOT_W-1:0]    slot_reg,     slot_next;
    logic [ROW_IDX_W-1:0] row_idx_reg,  row_idx_next;
    logic [ROW_IDX_W-1:0] ret_idx_reg,  ret_idx_next;
    logic [1:0]           inflight_reg, inflight_next;
    logic [ROW_W-1:0]     data_reg;
    logic                 start_reg,    start_next;
    logic                 first_reg,    first_next;
    logic                 last_reg,     last_next;
    logic                 done_reg;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [ROW_W-1:0]     fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic [ROW_IDX_W-1:0] row_idx_adv;
    logic [ROW_IDX_W-1:0] issue_idx;
    logic                 slot_end;
    logic                 issue_gate;
    logic                 issue_blk;
    logic                 ret_hit;
    logic                 done_evt;

    assign row_ready = !fifo_full;
    assign fifo_push = row_valid && !fifo_full;

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (fifo_push),
        .push_data (row_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        row_idx_adv = (row_idx_reg == ROW_LAST) ? '0 : row_idx_reg + ROW_IDX_W'(1);
        slot_end    = (state_reg == HOLD) && (slot_reg == SLOT_LAST);
        // At the end of a slot the gate is judged against the row about to be issued.
        issue_idx   = slot_end ? row_idx_adv : row_idx_reg;
        issue_gate  = (issue_idx != '0) || (inflight_reg < INFL_MAX);
        fifo_pop    = !fifo_empty && issue_gate && ((state_reg == IDLE) || slot_end);
        issue_blk   = fifo_pop && (issue_idx == '0);

        state_next = state_reg;
        slot_next  = slot_reg;
        if (fifo_pop) begin
            state_next = HOLD;
            slot_next  = '0;
        end else if (slot_end) begin
            state_next = IDLE;
            slot_next  = '0;
        end else if (state_reg == HOLD) begin
            slot_next = slot_reg + SLOT_W'(1);
        end
        row_idx_next = slot_end ? row_idx_adv : row_idx_reg;

        // Returns with nothing outstanding are a protocol error and are dropped.
        ret_hit      = data_en && (inflight_reg != '0);
        done_evt     = ret_hit && (ret_idx_reg == ROW_LAST);
        ret_idx_next = ret_idx_reg;
        if (ret_hit) begin
            ret_idx_next = (ret_idx_reg == ROW_LAST) ? '0 : ret_idx_reg + ROW_IDX_W'(1);
        end

        inflight_next = inflight_reg;
        unique case ({issue_blk, done_evt})
            2'b10:   inflight_next = inflight_reg + 2'd1;
            2'b01:   inflight_next = inflight_reg - 2'd1;
            default: inflight_next = inflight_reg;
        endcase

        start_next = (state_next == HOLD) && (slot_next == START_SLOT);
        first_next = start_next && (row_idx_next == '0);
        last_next  = start_next && (row_idx_next == ROW_LAST);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            slot_reg     <= '0;
            row_idx_reg  <= '0;
            ret_idx_reg  <= '0;
            inflight_reg <= '0;
            data_reg     <= '0;
            start_reg    <= 1'b0;
            first_reg    <= 1'b0;
            last_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_reg     <= slot_next;
            row_idx_reg  <= row_idx_next;
            ret_idx_reg  <= ret_idx_next;
            inflight_reg <= inflight_next;
            start_reg    <= start_next;
            first_reg    <= first_next;
            last_reg     <= last_next;
            done_reg     <= done_evt;
            if (fifo_pop) begin
                data_reg <= fifo_head;
            end
        end
    end

    assign DCT_data_in = data_reg;
    assign start       = start_reg;
    assign blk_first   = first_reg;
    assign blk_last    = last_reg;
    assign blk_done    = done_reg;
    assign inflight    = inflight_reg;
    assign busy        = !fifo_empty || (state_reg == HOLD) || (inflight_reg != '0);

endmodule

// File: tb/tb_dct_row_scheduler.sv
// Directed-plus-random bench for dct_row_scheduler against a queue-based
// behavioural model of the row issue, block gating and return counting.
module tb_dct_row_scheduler;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        row_valid = 1'b0;
    logic [95:0] row_data  = '0;
    logic        data_en   = 1'b0;
    logic        row_ready;
    logic [95:0] DCT_data_in;
    logic        start;
    logic        blk_first;
    logic        blk_last;
    logic        blk_done;
    logic [1:0]  inflight;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    dct_row_scheduler dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .row_valid   (row_valid),
        .row_data    (row_data),
        .row_ready   (row_ready),
        .DCT_data_in (DCT_data_in),
        .start       (start),
        .data_en     (data_en),
        .blk_first   (blk_first),
        .blk_last    (blk_last),
        .blk_done    (blk_done),
        .inflight    (inflight),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: rows waiting, the held row, slot position and block bookkeeping.
    logic [95:0] m_q[$];
    bit          m_hold;
    int          m_slot, m_row, m_ret, m_infl;
    logic [95:0] m_data;
    bit          m_start, m_first, m_last, m_done;

    logic [95:0] dir_rows[$];
    logic [95:0] cur_row;
    int          to_send = 0;
    bit          last_accept;
    int          start_seen = 0;

    function automatic logic [95:0] pack_row(int p0, int p1, int p2, int p3,
                                             int p4, int p5, int p6, int p7);
        return {12'(p0), 12'(p1), 12'(p2), 12'(p3), 12'(p4), 12'(p5), 12'(p6), 12'(p7)};
    endfunction

    function automatic logic [95:0] next_row();
        if (dir_rows.size() > 0) return dir_rows.pop_front();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold = 0; m_slot = 0; m_row = 0; m_ret = 0; m_infl = 0;
        m_data = '0; m_start = 0; m_first = 0; m_last = 0; m_done = 0;
    endtask

    task automatic model_edge(bit v, logic [95:0] d, bit den);
        bit push, slot_end, issue, done_now;
        int nidx;
        push     = v && (m_q.size() < 4);
        slot_end = m_hold && (m_slot == 7);
        nidx     = slot_end ? (m_row + 1) % 8 : m_row;
        issue    = (m_q.size() > 0) && (nidx != 0 || m_infl < 2) && (!m_hold || slot_end);
        done_now = den && (m_infl > 0) && (m_ret == 7);
        if (den && m_infl > 0) m_ret = (m_ret + 1) % 8;
        if (issue && nidx == 0) m_infl++;
        if (done_now) m_infl--;
        if (issue) begin
            m_data = m_q.pop_front();
            m_hold = 1;
            m_slot = 0;
        end else if (slot_end) begin
            m_hold = 0;
        end else if (m_hold) begin
            m_slot++;
        end
        m_row = nidx;
        if (push) m_q.push_back(d);
        m_start     = m_hold && (m_slot == 7);
        m_first     = m_start && (m_row == 0);
        m_last      = m_start && (m_row == 7);
        m_done      = done_now;
        last_accept = push;
    endtask

    task automatic check_all();
        chk("start",     96'(start),     96'(m_start));
        chk("data_in",   DCT_data_in,    m_data);
        chk("blk_first", 96'(blk_first), 96'(m_first));
        chk("blk_last",  96'(blk_last),  96'(m_last));
        chk("blk_done",  96'(blk_done),  96'(m_done));
        chk("inflight",  96'(inflight),  96'(m_infl));
        chk("busy",      96'(busy),      96'(m_q.size() > 0 || m_hold || m_infl != 0));
        chk("row_ready", 96'(row_ready), 96'(m_q.size() < 4));
    endtask

    task automatic step();
        bit          v;
        logic [95:0] d;
        bit          den;
        v = row_valid; d = row_data; den = data_en;
        @(posedge sys_clk);
        model_edge(v, d, den);
        #1;
        if (start === 1'b1) start_seen++;
        check_all();
    endtask

    task automatic run(int cycles, int pv, int pd);
        for (int i = 0; i < cycles; i++) begin
            if (to_send > 0 && $urandom_range(99) < pv) begin
                row_valid = 1'b1;
                row_data  = cur_row;
            end else begin
                row_valid = 1'b0;
            end
            data_en = ($urandom_range(99) < pd);
            step();
            if (last_accept) begin
                to_send--;
                cur_row = next_row();
            end
        end
        row_valid = 1'b0;
        data_en   = 1'b0;
    endtask

    task automatic async_reset();
        #2 sys_rst_n = 1'b0;
        row_valid = 1'b0;
        data_en   = 1'b0;
        #1;
        model_reset();
        check_all();
        to_send = 0;
        #2 sys_rst_n = 1'b1;
    endtask

    initial begin
        bit reached;
        model_reset();
        @(posedge sys_clk);
        #1;
        check_all();
        #4 sys_rst_n = 1'b1;

        // One full block back-to-back, no returns.
        dir_rows.push_back(pack_row(38, 43, 44, 45, 43, 39, 34, 35));
        dir_rows.push_back(pack_row(42, 41, 40, 44, 46, 43, 38, 36));
        dir_rows.push_back(pack_row(45, 44, 42, 41, 43, 45, 41, 39));
        dir_rows.push_back(pack_row(47, 46, 44, 40, 39, 42, 44, 41));
        dir_rows.push_back(pack_row(48, 47, 45, 42, 38, 40, 43, 42));
        dir_rows.push_back(pack_row(49, 46, 43, 41, 40, 39, 41, 43));
        dir_rows.push_back(pack_row(50, 47, 41, 39, 41, 40, 39, 41));
        dir_rows.push_back(pack_row(50, 45, 37, 38, 42, 40, 37, 40));
        cur_row = next_row();
        to_send = 8;
        start_seen = 0;
        run(90, 100, 0);
        chk("start_count", 96'(start_seen), 96'(8));
        chk("inflight_after_blk", 96'(inflight), 96'(1));

        // Eight returns complete the block.
        run(8, 0, 100);
        run(4, 0, 0);

        // Bubble after row 3, then resume.
        to_send = 4;
        run(40, 100, 0);
        run(20, 100, 0);
        to_send = 4;
        run(50, 100, 0);
        run(8, 0, 100);
        run(4, 0, 0);

        // Three blocks queued with no returns: gating and a full FIFO.
        to_send = 24;
        run(250, 100, 0);
        run(8, 0, 100);
        run(80, 100, 0);
        run(8, 0, 100);
        run(80, 100, 0);

        // Random traffic and returns, including returns with nothing outstanding.
        to_send = 400;
        run(3000, 70, 12);
        run(400, 0, 30);

        // Reset in the middle of a block, then a fresh block.
        to_send = 100;
        reached = 0;
        for (int i = 0; i < 400 && !reached; i++) begin
            run(1, 100, 0);
            if (m_hold && m_row == 5) reached = 1;
        end
        chk("reach_row5", 96'(reached), 96'(1));
        async_reset();
        cur_row = next_row();
        to_send = 8;
        run(90, 100, 0);
        run(8, 0, 100);
        run(4, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
